// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the pixel-clock PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Multi-flop bit synchroniser for the asynchronous PLL lock indication; resets to 0.
module pll_sup_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for lock with timeout/retry, qualifies
// stability, then releases sys_rst. Define LOCK_LOSS_CNT_EN to build the lock-loss counter.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_HOLD_CYC     = 50,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRIES      = 3,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                               i_refclk,
    input  logic                               i_rst,
    input  logic                               i_pll_locked,
    input  logic                               i_relock_req,
    output logic                               o_pll_rst,
    output logic                               o_sys_rst,
    output logic                               o_ready,
    output logic                               o_fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_cnt,
    output logic [LOSS_CNT_W-1:0]              o_lock_loss_cnt,
    output state_t                             o_state
);

    localparam int CNT_W   = $clog2(max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC) + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [RETRY_W-1:0]   r_retry;
    logic [RETRY_W-1:0]   w_retry_next;
    logic                 w_lk;
    logic                 r_pll_rst;
    logic                 r_sys_rst;
    logic                 r_ready;
    logic                 r_fault;

    pll_sup_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_lk)
    );

    always_comb begin
        w_next       = r_state;
        w_retry_next = r_retry;
        case (r_state)
            PLL_RST: begin
                if (r_cnt == CNT_W'(RST_HOLD_CYC - 1)) w_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_lk) begin
                    w_next = STABLE;
                end else if (r_cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    if (r_retry != RETRY_W'(MAX_RETRIES)) w_retry_next = r_retry + RETRY_W'(1);
                    w_next = (w_retry_next == RETRY_W'(MAX_RETRIES)) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!w_lk) w_next = WAIT_LOCK;
                else if (r_cnt == CNT_W'(LOCK_STABLE_CYC - 1)) w_next = RUN;
            end
            RUN: begin
                // A request and a lock loss in the same cycle is one re-acquisition.
                if (!w_lk || i_relock_req) begin
                    w_next       = PLL_RST;
                    w_retry_next = '0;
                end
            end
            FAULT: begin
                if (i_relock_req) begin
                    w_next       = PLL_RST;
                    w_retry_next = '0;
                end
            end
            default: w_next = PLL_RST;
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next != r_state) begin
            w_cnt_next = '0;
        end else if (r_state == PLL_RST || r_state == WAIT_LOCK || r_state == STABLE) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // Outputs are registered from the next state so they switch with the state itself.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state   <= PLL_RST;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_retry   <= w_retry_next;
            r_pll_rst <= (w_next == PLL_RST) || (w_next == FAULT);
            r_sys_rst <= (w_next != RUN);
            r_ready   <= (w_next == RUN);
            r_fault   <= (w_next == FAULT);
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    logic                  w_loss;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    assign w_loss = (r_state == RUN) && !w_lk;

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_loss_cnt <= '0;
        end else if (w_loss && (r_loss_cnt != '1)) begin
            r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
        end
    end

    assign o_lock_loss_cnt = r_loss_cnt;
`else
    assign o_lock_loss_cnt = '0;
`endif

    assign o_pll_rst   = r_pll_rst;
    assign o_sys_rst   = r_sys_rst;
    assign o_ready     = r_ready;
    assign o_fault     = r_fault;
    assign o_retry_cnt = r_retry;
    assign o_state     = r_state;

endmodule
